// File: rtl/complex_nr_mult_seq_pkg.sv
// Shared definitions for the sequential complex multiplier: FSM encodings,
// partial-product order and result width derivation.
package complex_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Partial-product sequence; index 1 is the only subtracted term.
  localparam logic [1:0] IDX_RE_RE = 2'd0;
  localparam logic [1:0] IDX_IM_IM = 2'd1;
  localparam logic [1:0] IDX_RE_IM = 2'd2;
  localparam logic [1:0] IDX_IM_RE = 2'd3;

  // One guard bit above the product width covers the (-2^(n-1))^2 * 2 corner.
  function automatic int calc_res_width(input int data_width);
    return 2 * data_width + 1;
  endfunction

endpackage

// File: rtl/complex_nr_mult_seq_if.sv
// Operand / result handshake bundle between a producer-consumer (master)
// and the complex multiplier (slave).
interface complex_nr_mult_seq_if
  import complex_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = calc_res_width(DATA_WIDTH)
);
  logic                         op_val;
  logic                         op_ready;
  logic signed [DATA_WIDTH-1:0] op_1_re;
  logic signed [DATA_WIDTH-1:0] op_1_im;
  logic signed [DATA_WIDTH-1:0] op_2_re;
  logic signed [DATA_WIDTH-1:0] op_2_im;
  logic                         res_val;
  logic                         res_ready;
  logic signed [RES_WIDTH-1:0]  res_re;
  logic signed [RES_WIDTH-1:0]  res_im;

  modport master (
    output op_val, op_1_re, op_1_im, op_2_re, op_2_im, res_ready,
    input  op_ready, res_val, res_re, res_im
  );

  modport slave (
    input  op_val, op_1_re, op_1_im, op_2_re, op_2_im, res_ready,
    output op_ready, res_val, res_re, res_im
  );
endinterface

// File: rtl/complex_nr_mult_seq_mac.sv
// Single signed multiplier feeding two add/subtract accumulators (real and
// imaginary); sum exposes the next accumulator value so the final term can
// be registered straight into the result.
module complex_mult_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 2 * DATA_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         load,
  input  logic                         sub,
  input  logic                         sel_im,
  input  logic signed [DATA_WIDTH-1:0] mul_a,
  input  logic signed [DATA_WIDTH-1:0] mul_b,
  output logic signed [RES_WIDTH-1:0]  acc_re,
  output logic signed [RES_WIDTH-1:0]  sum
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [RES_WIDTH-1:0]    prod_ext;
  logic signed [RES_WIDTH-1:0]    base;
  logic signed [RES_WIDTH-1:0]    acc_im;

  assign prod     = mul_a * mul_b;
  assign prod_ext = RES_WIDTH'(prod);
  // load starts a fresh accumulation instead of needing a separate clear cycle
  assign base     = load ? '0 : (sel_im ? acc_im : acc_re);
  assign sum      = sub ? (base - prod_ext) : (base + prod_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (clr) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en) begin
      if (sel_im) acc_im <= sum;
      else        acc_re <= sum;
    end
  end

endmodule

// File: rtl/complex_nr_mult_seq.sv
// Sequential complex multiplier: captures two complex operands, runs four
// partial products through one shared multiplier, holds the result until taken.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for op_val; capture operands, pulse op_ready
// ST_MUL  | one partial product per cycle, cnt selects the term 0..3
// ST_DONE | res_val high, result held until res_ready
module complex_nr_mult_seq
  import complex_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = calc_res_width(DATA_WIDTH)
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 sw_rst,
  complex_nr_mult_seq_if.slave bus
);

  state_t                       state;
  logic [1:0]                   cnt;
  logic                         op_ready_q;
  logic                         res_val_q;
  logic signed [RES_WIDTH-1:0]  res_re_q;
  logic signed [RES_WIDTH-1:0]  res_im_q;
  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;

  logic signed [DATA_WIDTH-1:0] mul_a, mul_b;
  logic signed [RES_WIDTH-1:0]  mac_acc_re, mac_sum;
  logic                         mac_en, mac_load, mac_sub, mac_sel_im;

  always_comb begin
    mul_a = a_re;
    mul_b = b_re;
    case (cnt)
      IDX_RE_RE: begin mul_a = a_re; mul_b = b_re; end
      IDX_IM_IM: begin mul_a = a_im; mul_b = b_im; end
      IDX_RE_IM: begin mul_a = a_re; mul_b = b_im; end
      default:   begin mul_a = a_im; mul_b = b_re; end
    endcase
  end

  assign mac_en     = (state == ST_MUL);
  assign mac_load   = (cnt == IDX_RE_RE) || (cnt == IDX_RE_IM);
  assign mac_sub    = (cnt == IDX_IM_IM);
  assign mac_sel_im = cnt[1];

  complex_mult_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .RES_WIDTH  (RES_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (sw_rst),
    .en     (mac_en),
    .load   (mac_load),
    .sub    (mac_sub),
    .sel_im (mac_sel_im),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .acc_re (mac_acc_re),
    .sum    (mac_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_ready_q <= 1'b0;
      res_val_q  <= 1'b0;
      res_re_q   <= '0;
      res_im_q   <= '0;
      a_re       <= '0;
      a_im       <= '0;
      b_re       <= '0;
      b_im       <= '0;
    end else if (sw_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_ready_q <= 1'b0;
      res_val_q  <= 1'b0;
      res_re_q   <= '0;
      res_im_q   <= '0;
      a_re       <= '0;
      a_im       <= '0;
      b_re       <= '0;
      b_im       <= '0;
    end else begin
      op_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.op_val) begin
            a_re       <= bus.op_1_re;
            a_im       <= bus.op_1_im;
            b_re       <= bus.op_2_re;
            b_im       <= bus.op_2_im;
            op_ready_q <= 1'b1;
            cnt        <= '0;
            state      <= ST_MUL;
          end
        end
        ST_MUL: begin
          cnt <= cnt + 2'd1;
          // last term goes straight from the adder so latency stays at four
          if (cnt == IDX_IM_RE) begin
            res_re_q  <= mac_acc_re;
            res_im_q  <= mac_sum;
            res_val_q <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            res_val_q <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_ready = op_ready_q;
  assign bus.res_val  = res_val_q;
  assign bus.res_re   = res_re_q;
  assign bus.res_im   = res_im_q;

endmodule

// File: tb/tb_complex_nr_mult_seq.sv
// Directed bench for complex_nr_mult_seq: handshake timing, corner operands,
// result hold, operand isolation, async and software reset.
module tb_complex_nr_mult_seq;

  logic clk;
  logic rst;
  logic sw_rst;

  complex_nr_mult_seq_if #(.DATA_WIDTH(8), .RES_WIDTH(17)) bus ();

  complex_nr_mult_seq #(.DATA_WIDTH(8), .RES_WIDTH(17)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_rst (sw_rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint res_re_s();
    return longint'($signed(bus.res_re));
  endfunction

  function automatic longint res_im_s();
    return longint'($signed(bus.res_im));
  endfunction

  // Present operands, wait for the acknowledge, then for the result (left in DONE).
  task automatic launch(input string tag, input logic [7:0] ar, ai, br, bi,
                        input longint er, input longint ei);
    int lat;
    int pulses;
    bit seen;
    bus.op_1_re = ar;
    bus.op_1_im = ai;
    bus.op_2_re = br;
    bus.op_2_im = bi;
    bus.op_val  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.op_ready) seen = 1'b1;
    end
    check_val({tag, "_ack"}, longint'(seen), 1);
    bus.op_val = 1'b0;
    lat = 0;
    pulses = 0;
    while (!bus.res_val && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.op_ready) pulses++;
    end
    check_val({tag, "_latency"}, lat, 4);
    check_val({tag, "_extra_ack"}, pulses, 0);
    check_val({tag, "_re"}, res_re_s(), er);
    check_val({tag, "_im"}, res_im_s(), ei);
  endtask

  task automatic accept(input string tag);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_val({tag, "_val_drop"}, longint'(bus.res_val), 0);
  endtask

  typedef struct {
    logic [7:0] ar, ai, br, bi;
    longint     er, ei;
    string      tag;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int changes;
    int cyc;
    int pulses;
    logic signed [7:0] r[4];
    longint mre, mim;

    vecs[0] = '{8'd2,   8'd3,   8'd4,   8'd2,   2, 16,    "basic"};
    vecs[1] = '{8'hFF,  8'hFF,  8'hFF,  8'hFF,  0, 2,     "minus_one"};
    vecs[2] = '{8'h80,  8'h80,  8'h80,  8'h80,  0, 32768, "most_neg"};

    rst = 1'b1;
    sw_rst = 1'b0;
    bus.op_val = 1'b0;
    bus.res_ready = 1'b0;
    bus.op_1_re = '0;
    bus.op_1_im = '0;
    bus.op_2_re = '0;
    bus.op_2_im = '0;
    repeat (2) @(negedge clk);
    check_val("rst_op_ready", longint'(bus.op_ready), 0);
    check_val("rst_res_val", longint'(bus.res_val), 0);
    check_val("rst_res_re", res_re_s(), 0);
    check_val("rst_res_im", res_im_s(), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i].tag, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi,
             vecs[i].er, vecs[i].ei);
      accept(vecs[i].tag);
    end

    // result held while consumer stalls; res_ready outside DONE must be harmless
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("ready_idle_res_im", res_im_s(), 32768);
    bus.res_ready = 1'b0;
    launch("hold", 8'd2, 8'd3, 8'd4, 8'd2, 2, 16);
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.res_val !== 1'b1 || res_re_s() != 2 || res_im_s() != 16) changes++;
    end
    check_val("hold_stable", changes, 0);
    accept("hold");
    repeat (3) @(negedge clk);
    check_val("retain_re", res_re_s(), 2);
    check_val("retain_im", res_im_s(), 16);

    // operand bus disturbed during MUL, op_val kept high into DONE
    bus.op_1_re = 8'd2;
    bus.op_1_im = 8'd3;
    bus.op_2_re = 8'd4;
    bus.op_2_im = 8'd2;
    bus.op_val = 1'b1;
    @(negedge clk);
    check_val("isol_ack", longint'(bus.op_ready), 1);
    bus.op_1_re = 8'd7;
    bus.op_1_im = 8'd7;
    bus.op_2_re = 8'd7;
    bus.op_2_im = 8'd7;
    cyc = 0;
    pulses = 0;
    while (!bus.res_val && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.op_ready) pulses++;
    end
    check_val("isol_latency", cyc, 4);
    check_val("isol_extra_ack", pulses, 0);
    check_val("isol_re", res_re_s(), 2);
    check_val("isol_im", res_im_s(), 16);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check_val("collide_val_drop", longint'(bus.res_val), 0);
    check_val("collide_no_ack", longint'(bus.op_ready), 0);
    @(negedge clk);
    check_val("collide_late_ack", longint'(bus.op_ready), 1);
    bus.op_val = 1'b0;
    cyc = 0;
    while (!bus.res_val && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_val("second_latency", cyc, 4);
    check_val("second_re", res_re_s(), 0);
    check_val("second_im", res_im_s(), 98);
    accept("second");

    // asynchronous reset in the middle of MUL
    bus.op_1_re = 8'd5;
    bus.op_1_im = 8'd1;
    bus.op_2_re = 8'd3;
    bus.op_2_im = 8'd4;
    bus.op_val = 1'b1;
    @(negedge clk);
    check_val("arst_ack", longint'(bus.op_ready), 1);
    bus.op_val = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_res_val", longint'(bus.res_val), 0);
    check_val("arst_res_im", res_im_s(), 0);
    check_val("arst_op_ready", longint'(bus.op_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_val || bus.op_ready) pulses++;
    end
    check_val("arst_no_output", pulses, 0);

    // software reset while the result waits in DONE
    launch("swr_pre", 8'd1, 8'd2, 8'd3, 8'd4, -5, 10);
    sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0;
    check_val("swr_res_val", longint'(bus.res_val), 0);
    check_val("swr_res_re", res_re_s(), 0);
    check_val("swr_res_im", res_im_s(), 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.res_val || bus.op_ready) pulses++;
    end
    check_val("swr_no_output", pulses, 0);
    launch("post_reset", 8'd2, 8'd3, 8'd4, 8'd2, 2, 16);
    accept("post_reset");

    // random back-to-back transactions against the arithmetic model
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) r[k] = 8'($urandom);
      mre = longint'(r[0]) * longint'(r[2]) - longint'(r[1]) * longint'(r[3]);
      mim = longint'(r[0]) * longint'(r[3]) + longint'(r[1]) * longint'(r[2]);
      launch($sformatf("rand%0d", t), r[0], r[1], r[2], r[3], mre, mim);
      accept($sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
